// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the per-line sprite scheduler.
package sprite_pkg;

   localparam int NUM_SPRITES = 32;
   localparam int SPRITE_SIZE = 16;
   localparam int NUM_SLOTS   = 4;
   localparam logic [5:0] NO_SPRITE_ID = 6'h3F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_COMMIT
   } state_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [5:0] layer;
   } sprite_attr_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] id;
      logic [9:0] x;
      logic [3:0] row;
   } slot_t;

   // Working-list entry: the slot payload plus the layer it is ranked by.
   typedef struct packed {
      slot_t      slot;
      logic [5:0] layer;
   } work_t;

endpackage

// File: rtl/sprite_slot_sorter.sv
// rtl/sprite_slot_sorter.sv - combinational priority insertion of one hit into the sorted working list.
module sprite_slot_sorter #(
   parameter int NUM_SLOTS = sprite_pkg::NUM_SLOTS
) (
   input  sprite_pkg::work_t [NUM_SLOTS-1:0] list_in,
   input  logic                              hit,
   input  sprite_pkg::work_t                 cand,
   output sprite_pkg::work_t [NUM_SLOTS-1:0] list_out
);
   import sprite_pkg::*;

   logic  [NUM_SLOTS-1:0] ahead;
   logic  [NUM_SLOTS-1:0] ahead_prev;
   work_t [NUM_SLOTS-1:0] shifted;

   // Valid entries are contiguous and sorted, so "ahead" is a thermometer code;
   // the candidate lands on the first slot that is not ahead of it.
   always_comb begin
      ahead = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         ahead[i] = list_in[i].slot.valid && (list_in[i].layer >= cand.layer);
      end
   end

   assign ahead_prev = {ahead[NUM_SLOTS-2:0], 1'b1};
   assign shifted    = {list_in[NUM_SLOTS-2:0], work_t'(0)};

   always_comb begin
      list_out = list_in;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (hit && !ahead[i]) begin
            list_out[i] = ahead_prev[i] ? cand : shifted[i];
         end
      end
   end

endmodule

// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - sprite attribute table plus per-line scan that commits up to four sprites by layer.
module sprite_line_scheduler #(
   parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES,
   parameter int SPRITE_SIZE = sprite_pkg::SPRITE_SIZE,
   parameter int NUM_SLOTS   = sprite_pkg::NUM_SLOTS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      line_start,
   input  logic [9:0]                line_v,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [4:0]                wr_idx,
   input  logic [9:0]                wr_x,
   input  logic [9:0]                wr_y,
   input  logic [5:0]                wr_layer,
   output logic [NUM_SLOTS-1:0]      slot_valid,
   output logic [NUM_SLOTS-1:0][4:0] slot_id,
   output logic [NUM_SLOTS-1:0][9:0] slot_x,
   output logic [NUM_SLOTS-1:0][3:0] slot_row,
   output logic                      done,
   output logic                      overflow,
   output logic                      overrun
);
   import sprite_pkg::*;

   state_t                state, next_state;
   logic [4:0]            idx;
   logic [9:0]            line_q;
   logic [2:0]            hit_cnt;
   work_t [NUM_SLOTS-1:0] work, work_next;
   sprite_attr_t          table_q [NUM_SPRITES];

   sprite_attr_t cur;
   logic [10:0]  y_end;
   logic         hit;
   work_t        cand;

   assign cur   = table_q[idx];
   assign y_end = {1'b0, cur.y} + 11'(SPRITE_SIZE - 1);
   assign hit   = (state == ST_SCAN) && (cur.layer != NO_SPRITE_ID) &&
                  (line_q >= cur.y) && ({1'b0, line_q} <= y_end);

   // Row only needs the low nibble: a hit guarantees line_q - y < 16.
   always_comb begin
      cand            = '0;
      cand.slot.valid = 1'b1;
      cand.slot.id    = idx;
      cand.slot.x     = cur.x;
      cand.slot.row   = line_q[3:0] - cur.y[3:0];
      cand.layer      = cur.layer;
   end

   sprite_slot_sorter #(.NUM_SLOTS(NUM_SLOTS)) u_sorter (
      .list_in  (work),
      .hit      (hit),
      .cand     (cand),
      .list_out (work_next)
   );

   assign wr_ready = (state == ST_IDLE) && !line_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (line_start) next_state = ST_SCAN;
         ST_SCAN:   if (idx == 5'(NUM_SPRITES - 1)) next_state = ST_COMMIT;
         ST_COMMIT: next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx        <= '0;
         line_q     <= '0;
         hit_cnt    <= '0;
         work       <= '0;
         slot_valid <= '0;
         slot_id    <= '0;
         slot_x     <= '0;
         slot_row   <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            table_q[i] <= '{x: 10'd0, y: 10'd0, layer: NO_SPRITE_ID};
         end
      end else begin
         done    <= 1'b0;
         overrun <= line_start && (state != ST_IDLE);
         if (wr_valid && wr_ready) begin
            table_q[wr_idx] <= '{x: wr_x, y: wr_y, layer: wr_layer};
         end
         case (state)
            ST_IDLE: begin
               if (line_start) begin
                  line_q  <= line_v;
                  idx     <= '0;
                  hit_cnt <= '0;
                  work    <= '0;
               end
            end
            ST_SCAN: begin
               idx  <= idx + 5'd1;
               work <= work_next;
               if (hit && (hit_cnt != 3'd5)) hit_cnt <= hit_cnt + 3'd1;
            end
            ST_COMMIT: begin
               for (int i = 0; i < NUM_SLOTS; i++) begin
                  slot_valid[i] <= work[i].slot.valid;
                  slot_id[i]    <= work[i].slot.id;
                  slot_x[i]     <= work[i].slot.x;
                  slot_row[i]   <= work[i].slot.row;
               end
               overflow <= (hit_cnt > 3'd4);
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb/tb_sprite_line_scheduler.sv - self-checking bench with a per-line ranking model of the scheduler.
module tb_sprite_line_scheduler;

   logic             clk = 1'b0;
   logic             rst, line_start, wr_valid, wr_ready;
   logic [9:0]       line_v, wr_x, wr_y;
   logic [4:0]       wr_idx;
   logic [5:0]       wr_layer;
   logic [3:0]       slot_valid;
   logic [3:0][4:0]  slot_id;
   logic [3:0][9:0]  slot_x;
   logic [3:0][3:0]  slot_row;
   logic             done, overflow, overrun;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 0;

   always #5 clk = ~clk;

   sprite_line_scheduler dut (
      .clk(clk), .rst(rst), .line_start(line_start), .line_v(line_v),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
      .wr_x(wr_x), .wr_y(wr_y), .wr_layer(wr_layer),
      .slot_valid(slot_valid), .slot_id(slot_id), .slot_x(slot_x),
      .slot_row(slot_row), .done(done), .overflow(overflow), .overrun(overrun)
   );

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: table contents, and the ranked result of a line known at scan start.
   int m_x[32], m_y[32], m_layer[32];
   int phase;
   bit p_valid[4], e_valid[4];
   int p_id[4], p_x[4], p_row[4], e_id[4], e_x[4], e_row[4];
   bit p_ovf, e_ovf, e_done, e_ovr;

   task automatic rank_line(input int l);
      bit is_hit[32];
      bit used[32];
      int hits = 0;
      for (int k = 0; k < 32; k++) begin
         is_hit[k] = (m_layer[k] != 63) && (l >= m_y[k]) && (l <= m_y[k] + 15);
         used[k] = 0;
         if (is_hit[k]) hits++;
      end
      for (int s = 0; s < 4; s++) begin
         int best = -1;
         for (int k = 0; k < 32; k++)
            if (is_hit[k] && !used[k] && (best < 0 || m_layer[k] > m_layer[best])) best = k;
         p_valid[s] = (best >= 0);
         p_id[s]  = (best >= 0) ? best : 0;
         p_x[s]   = (best >= 0) ? m_x[best] : 0;
         p_row[s] = (best >= 0) ? l - m_y[best] : 0;
         if (best >= 0) used[best] = 1;
      end
      p_ovf = (hits > 4);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 32; k++) begin m_x[k] = 0; m_y[k] = 0; m_layer[k] = 63; end
         for (int s = 0; s < 4; s++) begin e_valid[s] = 0; e_id[s] = 0; e_x[s] = 0; e_row[s] = 0; end
         phase = 0; e_ovf = 0; e_done = 0; e_ovr = 0;
      end else begin
         e_done = 0;
         e_ovr  = line_start && (phase != 0);
         if (phase != 0) begin
            phase++;
            if (phase == 34) begin
               for (int s = 0; s < 4; s++) begin
                  e_valid[s] = p_valid[s]; e_id[s] = p_id[s]; e_x[s] = p_x[s]; e_row[s] = p_row[s];
               end
               e_ovf = p_ovf; e_done = 1; phase = 0;
            end
         end else if (line_start) begin
            rank_line(int'(line_v));
            phase = 1;
         end else if (wr_valid) begin
            m_x[wr_idx] = wr_x; m_y[wr_idx] = wr_y; m_layer[wr_idx] = wr_layer;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("done", done, e_done);
         chk("overflow", overflow, e_ovf);
         chk("overrun", overrun, e_ovr);
         chk("wr_ready", wr_ready, (phase == 0) && !line_start);
         for (int s = 0; s < 4; s++) begin
            chk($sformatf("slot%0d_valid", s), slot_valid[s], e_valid[s]);
            chk($sformatf("slot%0d_id", s), slot_id[s], e_id[s]);
            chk($sformatf("slot%0d_x", s), slot_x[s], e_x[s]);
            chk($sformatf("slot%0d_row", s), slot_row[s], e_row[s]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_spr(input int i, input int x, input int y, input int layer);
      wr_valid = 1; wr_idx = 5'(i); wr_x = 10'(x); wr_y = 10'(y); wr_layer = 6'(layer);
      tick();
      wr_valid = 0;
   endtask

   // Pulses line_start and returns cycles until done; optional second line_start at ovr_at.
   task automatic scan(input int l, input int ovr_at, output int lat, output int wr_lat, output int ovr_c);
      line_start = 1; line_v = 10'(l);
      tick();
      line_start = 0;
      lat = -1; wr_lat = -1; ovr_c = -1;
      for (int c = 1; c <= 60; c++) begin
         line_start = (c == ovr_at);
         if (c == ovr_at) line_v = 10'd999;
         @(negedge clk);
         if (overrun && ovr_c < 0) ovr_c = c;
         if (wr_valid && wr_ready && wr_lat < 0) wr_lat = c;
         if (done) begin lat = c; break; end
         tick();
      end
      line_start = 0;
      if (lat < 0) chk("scan_timeout", lat, 34);
   endtask

   int lat, wl, oc;

   initial begin
      rst = 1; line_start = 0; line_v = 0; wr_valid = 0; wr_idx = 0; wr_x = 0; wr_y = 0; wr_layer = 0;
      tick(); started = 1; tick();
      rst = 0;
      @(negedge clk);
      chk("reset_valid", slot_valid, 0);
      chk("reset_done", done, 0);
      tick();

      scan(0, 0, lat, wl, oc);
      chk("empty_latency", lat, 34);
      chk("empty_valid", slot_valid, 0);
      chk("empty_overflow", overflow, 0);
      tick();

      write_spr(3, 100, 50, 5);
      scan(57, 0, lat, wl, oc);
      chk("s3_valid", slot_valid, 4'b0001);
      chk("s3_id", slot_id[0], 3);
      chk("s3_x", slot_x[0], 100);
      chk("s3_row", slot_row[0], 7);
      tick();
      scan(66, 0, lat, wl, oc);
      chk("s3_miss_valid", slot_valid, 0);
      tick();

      write_spr(0, 0, 10, 1);  write_spr(1, 20, 10, 9);  write_spr(2, 40, 10, 9);
      write_spr(3, 60, 10, 4); write_spr(4, 80, 10, 2);  write_spr(5, 100, 10, 7);
      scan(20, 0, lat, wl, oc);
      chk("six_id0", slot_id[0], 1);
      chk("six_id1", slot_id[1], 2);
      chk("six_id2", slot_id[2], 5);
      chk("six_id3", slot_id[3], 3);
      chk("six_x2", slot_x[2], 100);
      chk("six_overflow", overflow, 1);
      tick();

      write_spr(10, 300, 1016, 0);
      scan(1023, 0, lat, wl, oc);
      chk("edge_valid", slot_valid, 4'b0001);
      chk("edge_id", slot_id[0], 10);
      chk("edge_row", slot_row[0], 7);
      tick();
      scan(0, 0, lat, wl, oc);
      chk("edge_wrap_valid", slot_valid, 0);
      tick();

      wr_valid = 1; wr_idx = 5'd20; wr_x = 10'd500; wr_y = 10'd15; wr_layer = 6'd8;
      scan(20, 10, lat, wl, oc);
      chk("stall_latency", lat, 34);
      chk("stall_wr_ready_cycle", wl, 34);
      chk("overrun_cycle", oc, 11);
      chk("stall_id2", slot_id[2], 5);
      tick();
      wr_valid = 0;
      scan(20, 0, lat, wl, oc);
      chk("after_wr_id2", slot_id[2], 20);
      chk("after_wr_row2", slot_row[2], 5);
      chk("after_wr_id3", slot_id[3], 5);
      tick();

      line_start = 1; line_v = 10'd20;
      tick();
      line_start = 0;
      repeat (14) tick();
      rst = 1;
      #1;
      chk("rst_valid", slot_valid, 0);
      chk("rst_id0", slot_id[0], 0);
      chk("rst_overflow", overflow, 0);
      tick();
      rst = 0;
      tick();
      scan(20, 0, lat, wl, oc);
      chk("rst_rescan_latency", lat, 34);
      chk("rst_rescan_valid", slot_valid, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
